skew_shift_fifo: RTL and testbench

Multi-lane shift-register delay line that feeds the systolic array with row/column skew. It is the parametrised successor to the single-lane shift FIFO. Each lane has its own depth, so lane k is delayed by BASE_DEPTH + k*SKEW_STEP shifts. Each stage carries a valid bit, bubbles are zero-filled, the block supports a synchronous clear, and a busy flag tells the controller when the pipeline has drained.

---
 rtl/skew_shift_fifo_if.sv | 29 ++
 rtl/skew_shift_fifo.sv | 84 ++++++++
 tb/tb_skew_shift_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/skew_shift_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : skew_shift_fifo_if
// Brief    : Bus bundle for the multi-lane skewed shift delay line.
// Revision : 1.0 - initial release
// ============================================================================
interface skew_shift_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) ();
  logic [LANES*DATA_WIDTH-1:0] data_i;
  logic                        valid_i;
  logic                        shift_i;
  logic                        clear_i;
  logic [LANES*DATA_WIDTH-1:0] data_o;
  logic [LANES-1:0]            valid_o;
  logic                        busy_o;

  modport master (
    output data_i, valid_i, shift_i, clear_i,
    input  data_o, valid_o, busy_o
  );

  modport slave (
    input  data_i, valid_i, shift_i, clear_i,
    output data_o, valid_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/skew_shift_fifo.sv
`default_nettype none
// ============================================================================
// Module   : skew_shift_fifo
// Brief    : Per-lane shift delay line; lane k is BASE_DEPTH + k*SKEW_STEP deep.
// Revision : 1.0 - initial release
// ============================================================================
module skew_shift_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int BASE_DEPTH = 1,
  parameter int SKEW_STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  skew_shift_fifo_if.slave bus
);

  if (LANES < 1) begin : g_chk_lanes
    $fatal(1, "skew_shift_fifo: LANES must be >= 1");
  end
  if (BASE_DEPTH < 1) begin : g_chk_base
    $fatal(1, "skew_shift_fifo: BASE_DEPTH must be >= 1");
  end
  if (SKEW_STEP < 0) begin : g_chk_skew
    $fatal(1, "skew_shift_fifo: SKEW_STEP must be >= 0");
  end

  logic [LANES-1:0] w_lane_busy;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int c_depth = BASE_DEPTH + k * SKEW_STEP;

    // Stage 0 is the head, stage c_depth-1 is the tail.
    logic [c_depth-1:0][DATA_WIDTH-1:0] data_q;
    logic [c_depth-1:0][DATA_WIDTH-1:0] data_d;
    logic [c_depth-1:0]                 valid_q;
    logic [c_depth-1:0]                 valid_d;
    logic [c_depth-1:0][DATA_WIDTH-1:0] w_shift_data;
    logic [c_depth-1:0]                 w_shift_valid;
    logic [DATA_WIDTH-1:0]              w_tail_data;

    // Bubbles enter as zero so they add nothing downstream.
    assign w_tail_data = bus.valid_i ? bus.data_i[k*DATA_WIDTH +: DATA_WIDTH]
                                     : '0;

    if (c_depth > 1) begin : g_multi
      assign w_shift_data  = {w_tail_data, data_q[c_depth-1:1]};
      assign w_shift_valid = {bus.valid_i, valid_q[c_depth-1:1]};
    end else begin : g_single
      assign w_shift_data  = w_tail_data;
      assign w_shift_valid = bus.valid_i;
    end

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (bus.clear_i) begin
        data_d  = '0;
        valid_d = '0;
      end else if (bus.shift_i) begin
        data_d  = w_shift_data;
        valid_d = w_shift_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign bus.data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_q[0];
    assign bus.valid_o[k]                         = valid_q[0];
    assign w_lane_busy[k]                         = |valid_q;
  end

  assign bus.busy_o = |w_lane_busy;

endmodule
`default_nettype wire

// File: tb/tb_skew_shift_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_shift_fifo
// Brief    : Self-checking bench for skew_shift_fifo (default and 2x8 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_skew_shift_fifo;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } rec_t;

  typedef struct {
    logic        rst;
    logic        clr;
    logic        sh;
    logic        vld;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic [3:0]  exp_v;
    logic        exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  rec_t hist_a[$];
  rec_t hist_b[$];
  vec_t vecs[9];

  skew_shift_fifo_if #(.DATA_WIDTH(8),  .LANES(4)) ifa ();
  skew_shift_fifo_if #(.DATA_WIDTH(16), .LANES(2)) ifb ();

  skew_shift_fifo #(.DATA_WIDTH(8), .LANES(4), .BASE_DEPTH(1), .SKEW_STEP(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  skew_shift_fifo #(.DATA_WIDTH(16), .LANES(2), .BASE_DEPTH(8), .SKEW_STEP(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: a lane of depth D shows the record loaded D shifts ago (since the last flush).
  function automatic void model_out(input rec_t h[$], input int lanes, input int dw,
                                    input int base, input int step,
                                    output logic [31:0] ed, output logic [3:0] ev,
                                    output logic eb);
    ed = '0;
    ev = '0;
    eb = 1'b0;
    for (int k = 0; k < lanes; k++) begin
      int d;
      d = base + k * step;
      if (h.size() >= d && h[d-1].v) begin
        ev[k] = 1'b1;
        for (int b = 0; b < dw; b++) ed[k*dw + b] = h[d-1].d[k*dw + b];
      end
      for (int i = 0; i < d && i < h.size(); i++) if (h[i].v) eb = 1'b1;
    end
  endfunction

  task automatic tick();
    logic [31:0] ed;
    logic [3:0]  ev;
    logic        eb;
    @(posedge clk);
    if (reset || ifa.clear_i) hist_a.delete();
    else if (ifa.shift_i) begin
      hist_a.push_front('{v: ifa.valid_i, d: ifa.data_i});
      if (hist_a.size() > 4) void'(hist_a.pop_back());
    end
    if (reset || ifb.clear_i) hist_b.delete();
    else if (ifb.shift_i) begin
      hist_b.push_front('{v: ifb.valid_i, d: ifb.data_i});
      if (hist_b.size() > 8) void'(hist_b.pop_back());
    end
    @(negedge clk);
    model_out(hist_a, 4, 8, 1, 1, ed, ev, eb);
    chk("a_data",  ifa.data_o, ed);
    chk("a_valid", {28'd0, ifa.valid_o}, {28'd0, ev});
    chk("a_busy",  {31'd0, ifa.busy_o},  {31'd0, eb});
    model_out(hist_b, 2, 16, 8, 0, ed, ev, eb);
    chk("b_data",  ifb.data_o, ed);
    chk("b_valid", {30'd0, ifb.valid_o}, {30'd0, ev[1:0]});
    chk("b_busy",  {31'd0, ifb.busy_o},  {31'd0, eb});
  endtask

  task automatic drive_a(input logic clr, input logic sh, input logic vld, input logic [31:0] din);
    ifa.clear_i = clr;
    ifa.shift_i = sh;
    ifa.valid_i = vld;
    ifa.data_i  = din;
  endtask

  task automatic drive_b(input logic clr, input logic sh, input logic vld, input logic [31:0] din);
    ifb.clear_i = clr;
    ifb.shift_i = sh;
    ifb.valid_i = vld;
    ifb.data_i  = din;
  endtask

  // Load 0x44332211 into an empty default instance; lane 0 shows 0x11 at once.
  task automatic skew_load(input string tag);
    drive_a(1'b0, 1'b1, 1'b1, 32'h4433_2211);
    tick();
    chk({tag, "_l0_data"},  ifa.data_o, 32'h0000_0011);
    chk({tag, "_l0_valid"}, {28'd0, ifa.valid_o}, 32'h1);
    chk({tag, "_l0_busy"},  {31'd0, ifa.busy_o},  32'h1);
  endtask

  task automatic skew_tail(input string tag);
    logic [31:0] ed[4];
    logic [3:0]  ev[4];
    ed[0] = 32'h0000_2200; ev[0] = 4'b0010;
    ed[1] = 32'h0033_0000; ev[1] = 4'b0100;
    ed[2] = 32'h4400_0000; ev[2] = 4'b1000;
    ed[3] = 32'h0000_0000; ev[3] = 4'b0000;
    drive_a(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("%s_tail%0d_data", tag, i),  ifa.data_o, ed[i]);
      chk($sformatf("%s_tail%0d_valid", tag, i), {28'd0, ifa.valid_o}, {28'd0, ev[i]});
      chk($sformatf("%s_tail%0d_busy", tag, i),  {31'd0, ifa.busy_o}, (i < 3) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    drive_b(1'b0, 1'b0, 1'b0, 32'h0);

    //            rst   clr   sh    vld   din           exp_d         exp_v    exp_b
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h4433_2211, 32'h0000_0011, 4'b0001, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_2200, 4'b0010, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0033_0000, 4'b0100, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h4400_0000, 4'b1000, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 4'b0000, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      reset = vecs[i].rst;
      drive_a(vecs[i].clr, vecs[i].sh, vecs[i].vld, vecs[i].din);
      tick();
      chk($sformatf("vec%0d_data", i),  ifa.data_o, vecs[i].exp_d);
      chk($sformatf("vec%0d_valid", i), {28'd0, ifa.valid_o}, {28'd0, vecs[i].exp_v});
      chk($sformatf("vec%0d_busy", i),  {31'd0, ifa.busy_o},  {31'd0, vecs[i].exp_b});
    end

    // Stall: outputs frozen for five cycles, then the normal remaining latency.
    skew_load("stall");
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 1'b0, 1'b1, $urandom);
      tick();
      chk($sformatf("stall%0d_data", i),  ifa.data_o, 32'h0000_0011);
      chk($sformatf("stall%0d_valid", i), {28'd0, ifa.valid_o}, 32'h1);
      chk($sformatf("stall%0d_busy", i),  {31'd0, ifa.busy_o},  32'h1);
    end
    skew_tail("stall");

    // Clear beats a simultaneous shift; the 0xAA word is dropped.
    drive_a(1'b0, 1'b1, 1'b1, 32'h0102_0304);
    tick();
    drive_a(1'b0, 1'b1, 1'b1, 32'h0506_0708);
    tick();
    drive_a(1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA);
    tick();
    chk("clear_data",  ifa.data_o, 32'h0);
    chk("clear_valid", {28'd0, ifa.valid_o}, 32'h0);
    chk("clear_busy",  {31'd0, ifa.busy_o},  32'h0);
    drive_a(1'b0, 1'b1, 1'b0, 32'hAAAA_AAAA);
    repeat (5) tick();

    // Reset in the middle of a six-word burst.
    for (int w = 1; w <= 6; w++) begin
      logic [7:0] b;
      b = 8'(w);
      reset = (w == 3);
      drive_a(1'b0, 1'b1, 1'b1, {4{b}});
      tick();
      if (w == 3) begin
        chk("rstmid_data", ifa.data_o, 32'h0);
        chk("rstmid_busy", {31'd0, ifa.busy_o}, 32'h0);
      end
    end
    reset = 1'b0;
    drive_a(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) tick();
    skew_load("rstmid");
    skew_tail("rstmid");

    // Equal-depth instance: 16 words back to back, then drain.
    drive_a(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 24; i++) begin
      logic [15:0] w;
      logic [15:0] e;
      w = 16'(i);
      if (i <= 16) drive_b(1'b0, 1'b1, 1'b1, {w, w});
      else         drive_b(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      e = (i >= 8 && i <= 23) ? 16'(i - 7) : 16'h0;
      chk($sformatf("bstream%0d_l0", i), {16'd0, ifb.data_o[15:0]},  {16'd0, e});
      chk($sformatf("bstream%0d_l1", i), {16'd0, ifb.data_o[31:16]}, {16'd0, e});
      chk($sformatf("bstream%0d_valid", i), {30'd0, ifb.valid_o}, (e != 16'h0) ? 32'h3 : 32'h0);
    end

    // Random traffic on both instances against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive_a($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom);
      drive_b($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 6, $urandom);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
